seq_det_param: RTL and testbench
================================

Name: seq_det_param

Overview:
- Parametrised, runtime-configurable Moore sequence detector. Generalises the fixed 4-bit pattern detector to any pattern width and length, with a selectable overlap mode and a saturating match counter.
- Sits in the user project area behind mprj_io. Serial data, clock and reset arrive on GPIO inputs; detector_out drives an output pad.
- Configuration and the counter are visible to the management core through user-project logic.

Parameters:
- PAT_W, 4: maximum pattern length in bits (2..32).
- DEF_PATTERN, 4'b1011 (PAT_W bits): pattern loaded at reset.
- DEF_OVERLAP, 1: overlap mode loaded at reset.
- CNT_W, 8: match counter width (2..32).

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset (0 = reset).
- sequence_in, input, 1: serial data bit.
- in_valid, input, 1: sequence_in is sampled only when 1.
- cfg_load, input, 1: one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, input, PAT_W: new pattern. The last-received bit maps to bit 0.
- cfg_len, input, $clog2(PAT_W+1): active pattern length.
- cfg_overlap, input, 1: 1 = overlapping matches, 0 = non-overlapping.
- cnt_clr, input, 1: clears match_count and count_sat.
- detector_out, output, 1: registered Moore output, high only in state HIT.
- match_count, output, CNT_W: number of matches, saturating.
- count_sat, output, 1: sticky flag; set when match_count reaches all-ones.

Behaviour:
- Reset values (reset==0 at a rising edge):
  - state IDLE; detector_out 0; match_count 0; count_sat 0.
  - history 0; fill 0.
  - pattern = DEF_PATTERN; len = PAT_W; overlap = DEF_OVERLAP.
- Length rule: a cfg_len of 0 or greater than PAT_W is stored as PAT_W.
- Sampling, on a valid edge (in_valid==1, cfg_load==0):
  - hist_next = {hist[PAT_W-2:0], sequence_in}.
  - fill_next = min(fill+1, PAT_W).
- Match condition: fill_next >= len AND hist_next[len-1:0] == pattern[len-1:0]. The first-received bit of the pattern is pattern[len-1].
- FSM states:
  - IDLE: fill==0.
  - SHIFT: 0 < fill, no match on the last edge.
  - HIT: a match occurred on the last edge.
- FSM transitions, evaluated each edge:
  - Valid edge with match: go to HIT (HIT->HIT allowed for back-to-back matches).
  - Valid edge without match: go to SHIFT.
  - No valid bit: IDLE stays IDLE; SHIFT stays SHIFT; HIT goes to SHIFT if fill>0, else IDLE.
- Latency: detector_out rises in the cycle immediately after the edge that sampled the final pattern bit. It is a one-cycle pulse per match.
- Overlap mode 1: history and fill are retained after a match, so a suffix of a match can start the next one.
- Overlap mode 0: on the matching edge, hist_next and fill_next are forced to 0. The next match needs len fresh bits.
- Counter:
  - On each entry to HIT, match_count increments, saturating at 2^CNT_W-1.
  - count_sat goes to 1 on the edge where the count reaches all-ones and stays 1.
- cnt_clr: clears the counter and count_sat.
  - If a match occurs on the same edge, the clear wins and match_count becomes 1.
  - count_sat becomes 1 on that edge only if all-ones equals 1.
- cfg_load:
  - Latches pattern, len and overlap; clears hist and fill; state goes to IDLE; detector_out goes to 0.
  - Has priority over in_valid; a bit presented on the same edge is dropped.
  - Does not affect match_count.
- Reset asserted mid-sequence: partial history is discarded and configuration reverts to the defaults. Bits arriving after reset release start from empty history.

Optional Feature:
- Macro SEQ_DET_IRQ_EN.
- When defined, the block adds:
  - input irq_clr (1 bit).
  - output irq (1 bit, reset 0). irq is set on any entry to HIT and stays set until irq_clr.
  - If irq_clr and a match occur on the same edge, set wins and irq stays 1.
- When undefined: no irq or irq_clr ports and no irq logic. All other behaviour is identical.

Test Plan:
- Defaults (1011, overlap=1), stream 0,0,1,0,1,1 with in_valid=1 -> detector_out pulses exactly one cycle after the 6th sampled bit; match_count=1.
- Overlap=1, stream 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; match_count=2. Same stream after cfg_load with overlap=0 -> single pulse after bit 4; count=3 total.
- cfg_load with cfg_pattern=3'b101 (upper bits 0), cfg_len=3, overlap=1; stream 1,0,1,0,1 -> pulses after bits 3 and 5. A bit sent on the cfg_load edge is ignored.
- CNT_W=2, pattern 1111 overlap=1, stream of seven 1s -> four pulses (bits 4..7, consecutive HIT cycles); match_count=3; count_sat=1. cnt_clr then gives 0/0.
- Send 1,0,1, assert reset low for one edge, release, send 1 -> no pulse; match_count=0; pattern back to 1011.
- in_valid gaps: 1,0,(gap 3 cycles),1,1 -> one pulse after the final bit. With SEQ_DET_IRQ_EN defined, irq=1 until irq_clr, then 0.

Source files
------------

// File: rtl/seq_det_param.sv
// Runtime-configurable Moore sequence detector with overlap mode and a saturating match counter.
// Optional interrupt output (irq/irq_clr) is built when SEQ_DET_IRQ_EN is defined.
module seq_det_param #(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(4'b1011),
  parameter bit               DEF_OVERLAP = 1'b1,
  parameter int               CNT_W       = 8,
  localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
`ifdef SEQ_DET_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, HIT} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic             overlap_q;
  // The oldest history bit is shifted out before any compare, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] len_cfg;
  logic             sample;
  logic             match;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    sample     = in_valid & ~cfg_load;
    hist_shift = {hist_q, sequence_in};
    fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = sample && (fill_inc >= len_q) &&
            (((hist_shift ^ pattern_q) & len_mask) == '0);

    len_cfg = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

    hist_d = hist_q;
    fill_d = fill_q;
    if (sample) begin
      if (match && !overlap_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift[PAT_W-2:0];
        fill_d = fill_inc;
      end
    end

    state_d = state_q;
    if (cfg_load) begin
      state_d = IDLE;
    end else if (sample) begin
      state_d = match ? HIT : SHIFT;
    end else if (state_q == HIT) begin
      state_d = (fill_q != '0) ? SHIFT : IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      detector_out <= 1'b0;
      pattern_q    <= DEF_PATTERN;
      len_q        <= LEN_MAX;
      overlap_q    <= DEF_OVERLAP;
      hist_q       <= '0;
      fill_q       <= '0;
      match_count  <= '0;
      count_sat    <= 1'b0;
    end else begin
      state_q      <= state_d;
      detector_out <= (state_d == HIT);

      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        len_q     <= len_cfg;
        overlap_q <= cfg_overlap;
        hist_q    <= '0;
        fill_q    <= '0;
      end else begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end

      // A clear coinciding with a match restarts the count at one.
      if (cnt_clr) begin
        match_count <= match ? CNT_W'(1) : '0;
        count_sat   <= match && (CNT_MAX == CNT_W'(1));
      end else if (match && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
        if (match_count + CNT_W'(1) == CNT_MAX) count_sat <= 1'b1;
      end
    end
  end

`ifdef SEQ_DET_IRQ_EN
  // Set has priority over clear so a match on the clearing edge is not lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq <= 1'b0;
    end else if (match) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed self-checking bench for seq_det_param; a second instance with CNT_W=2 covers saturation.
module tb_seq_det_param;

  logic       clock;
  logic       reset;
  logic       sequence_in;
  logic       in_valid;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       detector_out, detector_out2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       count_sat, count_sat2;
`ifdef SEQ_DET_IRQ_EN
  logic       irq_clr;
  logic       irq, irq2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  seq_det_param u_dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .cnt_clr      (cnt_clr),
    .detector_out (detector_out),
    .match_count  (match_count),
    .count_sat    (count_sat)
`ifdef SEQ_DET_IRQ_EN
    ,
    .irq_clr      (irq_clr),
    .irq          (irq)
`endif
  );

  seq_det_param #(.CNT_W(2)) u_dut_sat (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .cnt_clr      (cnt_clr),
    .detector_out (detector_out2),
    .match_count  (match_count2),
    .count_sat    (count_sat2)
`ifdef SEQ_DET_IRQ_EN
    ,
    .irq_clr      (irq_clr),
    .irq          (irq2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step(input logic v, input logic b);
    in_valid    = v;
    sequence_in = b;
    @(posedge clock);
    #1;
    in_valid    = 1'b0;
  endtask

  task automatic load_cfg(input logic [3:0] pat, input logic [2:0] len, input logic ov,
                          input logic drop_bit);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    step(drop_bit, 1'b1);
    cfg_load    = 1'b0;
    check("load_det", 32'(detector_out), 32'd0);
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    cnt_clr = 1'b0;
  endtask

  // bits/exp are listed first-sent at the MSB end of the n-bit field.
  task automatic run_stream(input string tag, input logic [7:0] bits, input int n,
                            input logic [7:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i]);
      check($sformatf("%s_bit%0d", tag, n - i), 32'(detector_out), 32'(exp[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; sequence_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 4'b0; cfg_len = 3'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
`ifdef SEQ_DET_IRQ_EN
    irq_clr = 1'b0;
`endif
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_det", 32'(detector_out), 32'd0);
    check("rst_cnt", 32'(match_count), 32'd0);
    check("rst_sat", 32'(count_sat), 32'd0);
    reset = 1'b1;

    // Default pattern 1011, overlapping
    run_stream("t1", 8'b001011, 6, 8'b000001);
    check("t1_cnt", 32'(match_count), 32'd1);
    step(1'b0, 1'b0);
    check("t1_pulse_end", 32'(detector_out), 32'd0);

    // Overlap vs non-overlap on the same stream
    clr_cnt();
    check("t2_clr", 32'(match_count), 32'd0);
    load_cfg(4'b1011, 3'd4, 1'b1, 1'b0);
    run_stream("t2_ov1", 8'b1011011, 7, 8'b0001001);
    check("t2_cnt_ov1", 32'(match_count), 32'd2);
    load_cfg(4'b1011, 3'd4, 1'b0, 1'b0);
    check("t2_load_keeps_cnt", 32'(match_count), 32'd2);
    run_stream("t2_ov0", 8'b1011011, 7, 8'b0001000);
    check("t2_cnt_ov0", 32'(match_count), 32'd3);

    // Short pattern 101; the bit on the load edge must be dropped
    load_cfg(4'b0101, 3'd3, 1'b1, 1'b1);
    run_stream("t3_drop", 8'b01, 2, 8'b00);
    load_cfg(4'b0101, 3'd3, 1'b1, 1'b0);
    run_stream("t3", 8'b10101, 5, 8'b00101);
    check("t3_cnt", 32'(match_count), 32'd5);

    // Out-of-range lengths fall back to full width
    load_cfg(4'b1011, 3'd0, 1'b1, 1'b0);
    run_stream("t3_len0", 8'b011, 3, 8'b000);
    load_cfg(4'b1011, 3'd7, 1'b1, 1'b0);
    run_stream("t3_len7", 8'b011, 3, 8'b000);

    // Saturation on the 2-bit counter instance, back-to-back hits
    clr_cnt();
    load_cfg(4'b1111, 3'd4, 1'b1, 1'b0);
    run_stream("t4", 8'b1111111, 7, 8'b0001111);
    check("t4_sat_cnt", 32'(match_count2), 32'd3);
    check("t4_sat_flag", 32'(count_sat2), 32'd1);
    check("t4_wide_cnt", 32'(match_count), 32'd4);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    cnt_clr = 1'b0;
    check("t4_clr_hit_det", 32'(detector_out), 32'd1);
    check("t4_clr_hit_cnt", 32'(match_count2), 32'd1);
    check("t4_clr_hit_sat", 32'(count_sat2), 32'd0);
    clr_cnt();
    check("t4_clr_cnt", 32'(match_count2), 32'd0);
    check("t4_clr_sat", 32'(count_sat2), 32'd0);

    // Mid-sequence reset discards history and restores the default pattern
    load_cfg(4'b0001, 3'd4, 1'b1, 1'b0);
    run_stream("t5_pre", 8'b101, 3, 8'b000);
    reset = 1'b0;
    step(1'b0, 1'b0);
    reset = 1'b1;
    check("t5_rst_cnt", 32'(match_count), 32'd0);
    run_stream("t5_post", 8'b1011, 4, 8'b0001);
    check("t5_cnt", 32'(match_count), 32'd1);

    // in_valid gaps do not break the sequence
    load_cfg(4'b1011, 3'd4, 1'b1, 1'b0);
`ifdef SEQ_DET_IRQ_EN
    irq_clr = 1'b1;
    step(1'b0, 1'b0);
    irq_clr = 1'b0;
    check("t6_irq_clr0", 32'(irq), 32'd0);
`endif
    run_stream("t6_a", 8'b10, 2, 8'b00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check($sformatf("t6_gap%0d", i), 32'(detector_out), 32'd0);
    end
    run_stream("t6_b", 8'b11, 2, 8'b01);
    check("t6_cnt", 32'(match_count), 32'd2);
    step(1'b0, 1'b0);
    check("t6_pulse_end", 32'(detector_out), 32'd0);
`ifdef SEQ_DET_IRQ_EN
    check("t6_irq_held", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    step(1'b0, 1'b0);
    irq_clr = 1'b0;
    check("t6_irq_cleared", 32'(irq), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
